// File: rtl/fetch_unit.sv
// Instruction fetch stage: one outstanding single-word request, buffering of a
// response under stall, stale-response discard after redirect, fetch-fault reporting.
module fetch_unit #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_address,
  output logic        mem_valid,
  output logic [31:0] mem_address,
  input  logic        mem_ready,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  input  logic        mem_error,
  output logic [31:0] pc_out,
  output logic [31:0] next_pc_out,
  output logic [31:0] instruction_out,
  output logic        valid_out,
  output logic        exception_out,
  output logic [3:0]  ecause_out
);

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD, S_HALT} state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [31:0] buf_data;
  logic        buf_error;
  logic        discard;
  logic        mis_pending;
  logic        accept;
  logic        in_flight;
  logic        deliver;
  logic        deliver_fault;
  logic [3:0]  deliver_cause;
  logic [31:0] deliver_data;

  // No new request while a dropped response is still owed by memory.
  assign mem_valid   = reset_n && (state == S_REQ) && !discard;
  assign mem_address = pc;
  assign accept      = mem_valid && mem_ready;
  assign pc_plus4    = pc + 32'd4;
  assign in_flight   = accept || (((state == S_WAIT) || discard) && !mem_rvalid);

  always_comb begin
    deliver       = 1'b0;
    deliver_fault = 1'b0;
    deliver_cause = 4'd0;
    deliver_data  = mem_rdata;
    if (!redirect && !stall) begin
      case (state)
        S_WAIT: begin
          if (mem_rvalid && !discard) begin
            deliver       = 1'b1;
            deliver_fault = mem_error;
            deliver_cause = 4'd1;
          end
        end
        S_HOLD: begin
          deliver       = 1'b1;
          deliver_fault = buf_error;
          deliver_cause = 4'd1;
          deliver_data  = buf_data;
        end
        S_HALT: begin
          if (mis_pending) begin
            deliver       = 1'b1;
            deliver_fault = 1'b1;
            deliver_cause = 4'd0;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state           <= S_REQ;
      pc              <= RESET_VECTOR;
      discard         <= 1'b0;
      mis_pending     <= 1'b0;
      buf_data        <= 32'd0;
      buf_error       <= 1'b0;
      pc_out          <= 32'd0;
      next_pc_out     <= 32'd0;
      instruction_out <= 32'd0;
      valid_out       <= 1'b0;
      exception_out   <= 1'b0;
      ecause_out      <= 4'd0;
    end else if (redirect) begin
      pc            <= redirect_address;
      discard       <= in_flight;
      buf_error     <= 1'b0;
      valid_out     <= 1'b0;
      exception_out <= 1'b0;
      mis_pending   <= (redirect_address[1:0] != 2'b00);
      if (redirect_address[1:0] != 2'b00)
        state <= S_HALT;
      else if (in_flight)
        state <= S_WAIT;
      else
        state <= S_REQ;
    end else begin
      if (mem_rvalid && discard)
        discard <= 1'b0;
      if (!stall) begin
        valid_out     <= 1'b0;
        exception_out <= 1'b0;
      end
      if (deliver) begin
        pc_out          <= pc;
        next_pc_out     <= pc_plus4;
        instruction_out <= deliver_fault ? 32'd0 : deliver_data;
        valid_out       <= 1'b1;
        exception_out   <= deliver_fault;
        ecause_out      <= deliver_fault ? deliver_cause : 4'd0;
        mis_pending     <= 1'b0;
        // A faulting fetch parks the unit until the next redirect.
        if (deliver_fault) begin
          state <= S_HALT;
        end else begin
          pc    <= pc_plus4;
          state <= S_REQ;
        end
      end else begin
        case (state)
          S_REQ: begin
            if (accept)
              state <= S_WAIT;
          end
          S_WAIT: begin
            if (mem_rvalid) begin
              if (discard) begin
                state <= S_REQ;
              end else begin
                buf_data  <= mem_rdata;
                buf_error <= mem_error;
                state     <= S_HOLD;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed vector table plus a randomized
// run against a transaction-level model of the expected instruction stream.
module tb_fetch_unit;

  logic        clk;
  logic        reset_n;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_address;
  logic        mem_valid;
  logic [31:0] mem_address;
  logic        mem_ready;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        mem_error;
  logic [31:0] pc_out;
  logic [31:0] next_pc_out;
  logic [31:0] instruction_out;
  logic        valid_out;
  logic        exception_out;
  logic [3:0]  ecause_out;

  int tests_run    = 0;
  int tests_failed = 0;

  typedef struct {
    logic        stall;
    logic        redirect;
    logic [31:0] raddr;
    logic        ready;
    logic        rvalid;
    logic [31:0] rdata;
    logic        err;
    logic        e_mv;
    logic [31:0] e_ma;
    logic        e_v;
    logic [31:0] e_pc;
    logic [31:0] e_instr;
    logic        e_exc;
    logic [3:0]  e_cause;
  } vec_t;

  vec_t vecs[$];

  // Random-phase model state
  logic        mv, rdy, s, r, rv, pend, halted, m_valid, e;
  logic [31:0] ma, ra, paddr, exp_pc, m_pc;
  int          lat, halt_cnt, deliveries;

  localparam logic [31:0] A0   = 32'h1111_0000;
  localparam logic [31:0] A4   = 32'h2222_0004;
  localparam logic [31:0] A8   = 32'h3333_0008;
  localparam logic [31:0] A100 = 32'h4444_0100;
  localparam logic [31:0] AFFC = 32'h5555_FFFC;
  localparam logic [31:0] A0B  = 32'h6666_0000;
  localparam logic [31:0] A300 = 32'h7777_0300;
  localparam logic [31:0] JUNK = 32'hDEAD_BEEF;

  fetch_unit #(.RESET_VECTOR(32'h0000_0000)) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .stall            (stall),
    .redirect         (redirect),
    .redirect_address (redirect_address),
    .mem_valid        (mem_valid),
    .mem_address      (mem_address),
    .mem_ready        (mem_ready),
    .mem_rvalid       (mem_rvalid),
    .mem_rdata        (mem_rdata),
    .mem_error        (mem_error),
    .pc_out           (pc_out),
    .next_pc_out      (next_pc_out),
    .instruction_out  (instruction_out),
    .valid_out        (valid_out),
    .exception_out    (exception_out),
    .ecause_out       (ecause_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic st, input logic rd, input logic [31:0] ra_i,
                              input logic rdy_i, input logic rv_i, input logic [31:0] rdat,
                              input logic er, input logic emv, input logic [31:0] ema,
                              input logic ev, input logic [31:0] epc, input logic [31:0] ei,
                              input logic eex, input logic [3:0] ec);
    vec_t v;
    v.stall = st;  v.redirect = rd; v.raddr = ra_i; v.ready = rdy_i;
    v.rvalid = rv_i; v.rdata = rdat; v.err = er;
    v.e_mv = emv;  v.e_ma = ema;    v.e_v = ev;     v.e_pc = epc;
    v.e_instr = ei; v.e_exc = eex;  v.e_cause = ec;
    return v;
  endfunction

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  function automatic logic errf(input logic [31:0] a);
    return (a[7:2] == 6'h2A);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // Entered just after a rising edge; drives one cycle and checks both the
  // request seen during the cycle and the registered outputs after the edge.
  task automatic applyStimulus(input vec_t v, input int idx);
    stall            = v.stall;
    redirect         = v.redirect;
    redirect_address = v.raddr;
    mem_ready        = v.ready;
    mem_rvalid       = v.rvalid;
    mem_rdata        = v.rdata;
    mem_error        = v.err;
    #3;
    checkOutput($sformatf("vec%0d_mem_valid", idx), {31'd0, mem_valid}, {31'd0, v.e_mv});
    if (v.e_mv)
      checkOutput($sformatf("vec%0d_mem_address", idx), mem_address, v.e_ma);
    @(posedge clk);
    #1;
    checkOutput($sformatf("vec%0d_valid_out", idx), {31'd0, valid_out}, {31'd0, v.e_v});
    checkOutput($sformatf("vec%0d_exception_out", idx), {31'd0, exception_out}, {31'd0, v.e_exc});
    if (v.e_v) begin
      checkOutput($sformatf("vec%0d_pc_out", idx), pc_out, v.e_pc);
      checkOutput($sformatf("vec%0d_next_pc_out", idx), next_pc_out, v.e_pc + 32'd4);
      checkOutput($sformatf("vec%0d_instruction_out", idx), instruction_out, v.e_instr);
    end
    if (v.e_exc)
      checkOutput($sformatf("vec%0d_ecause_out", idx), {28'd0, ecause_out}, {28'd0, v.e_cause});
  endtask

  initial begin
    reset_n = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_address = 32'd0;
    mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'd0; mem_error = 1'b0;
    #2;
    checkOutput("reset_mem_valid", {31'd0, mem_valid}, 32'd0);
    checkOutput("reset_valid_out", {31'd0, valid_out}, 32'd0);
    checkOutput("reset_pc_out", pc_out, 32'd0);
    checkOutput("reset_next_pc_out", next_pc_out, 32'd0);
    checkOutput("reset_instruction_out", instruction_out, 32'd0);
    checkOutput("reset_exception_out", {31'd0, exception_out}, 32'd0);
    checkOutput("reset_ecause_out", {28'd0, ecause_out}, 32'd0);
    #10;
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Sequential fetch, stall with buffered response, redirects, faults, wrap.
    vecs.push_back(mk(0,0,0,            1,0,0,0,    1,32'h0,        0,0,0,0,0));
    vecs.push_back(mk(0,0,0,            0,1,A0,0,   0,0,            1,32'h0,A0,0,0));
    vecs.push_back(mk(1,0,0,            1,0,0,0,    1,32'h4,        1,32'h0,A0,0,0));
    vecs.push_back(mk(1,0,0,            0,1,A4,0,   0,0,            1,32'h0,A0,0,0));
    vecs.push_back(mk(1,0,0,            1,0,0,0,    0,0,            1,32'h0,A0,0,0));
    vecs.push_back(mk(1,0,0,            1,0,0,0,    0,0,            1,32'h0,A0,0,0));
    vecs.push_back(mk(1,0,0,            1,0,0,0,    0,0,            1,32'h0,A0,0,0));
    vecs.push_back(mk(0,0,0,            0,0,0,0,    0,0,            1,32'h4,A4,0,0));
    vecs.push_back(mk(0,0,0,            1,0,0,0,    1,32'h8,        0,0,0,0,0));
    vecs.push_back(mk(0,1,32'h100,      0,0,0,0,    0,0,            0,0,0,0,0));
    vecs.push_back(mk(0,0,0,            0,1,A8,0,   0,0,            0,0,0,0,0));
    vecs.push_back(mk(0,0,0,            1,0,0,0,    1,32'h100,      0,0,0,0,0));
    vecs.push_back(mk(0,0,0,            0,1,A100,0, 0,0,            1,32'h100,A100,0,0));
    vecs.push_back(mk(0,1,32'h102,      0,0,0,0,    1,32'h104,      0,0,0,0,0));
    vecs.push_back(mk(0,0,0,            0,0,0,0,    0,0,            1,32'h102,0,1,0));
    vecs.push_back(mk(0,0,0,            1,0,0,0,    0,0,            0,0,0,0,0));
    vecs.push_back(mk(0,0,0,            1,0,0,0,    0,0,            0,0,0,0,0));
    vecs.push_back(mk(0,1,32'h40,       0,0,0,0,    0,0,            0,0,0,0,0));
    vecs.push_back(mk(0,0,0,            1,0,0,0,    1,32'h40,       0,0,0,0,0));
    vecs.push_back(mk(0,0,0,            0,1,JUNK,1, 0,0,            1,32'h40,0,1,1));
    vecs.push_back(mk(0,0,0,            1,0,0,0,    0,0,            0,0,0,0,0));
    vecs.push_back(mk(0,0,0,            1,0,0,0,    0,0,            0,0,0,0,0));
    vecs.push_back(mk(0,1,32'h200,      0,0,0,0,    0,0,            0,0,0,0,0));
    vecs.push_back(mk(0,0,0,            1,0,0,0,    1,32'h200,      0,0,0,0,0));
    vecs.push_back(mk(0,1,32'hFFFF_FFFC,0,0,0,0,    0,0,            0,0,0,0,0));
    vecs.push_back(mk(0,0,0,            0,1,JUNK,0, 0,0,            0,0,0,0,0));
    vecs.push_back(mk(0,0,0,            1,0,0,0,    1,32'hFFFF_FFFC,0,0,0,0,0));
    vecs.push_back(mk(0,0,0,            0,1,AFFC,0, 0,0,            1,32'hFFFF_FFFC,AFFC,0,0));
    vecs.push_back(mk(0,0,0,            1,0,0,0,    1,32'h0,        0,0,0,0,0));
    vecs.push_back(mk(0,0,0,            0,1,A0B,0,  0,0,            1,32'h0,A0B,0,0));
    vecs.push_back(mk(0,1,32'h300,      1,0,0,0,    1,32'h4,        0,0,0,0,0));
    vecs.push_back(mk(0,0,0,            0,1,JUNK,0, 0,0,            0,0,0,0,0));
    vecs.push_back(mk(0,0,0,            1,0,0,0,    1,32'h300,      0,0,0,0,0));
    vecs.push_back(mk(0,0,0,            0,1,A300,0, 0,0,            1,32'h300,A300,0,0));
    vecs.push_back(mk(1,1,32'h400,      0,0,0,0,    1,32'h304,      0,0,0,0,0));
    vecs.push_back(mk(0,0,0,            1,0,0,0,    1,32'h400,      0,0,0,0,0));
    vecs.push_back(mk(1,0,0,            0,1,JUNK,1, 0,0,            0,0,0,0,0));
    vecs.push_back(mk(0,0,0,            0,0,0,0,    0,0,            1,32'h400,0,1,1));
    vecs.push_back(mk(0,0,0,            1,0,0,0,    0,0,            0,0,0,0,0));
    vecs.push_back(mk(0,1,32'h500,      0,0,0,0,    0,0,            0,0,0,0,0));
    vecs.push_back(mk(0,0,0,            1,0,0,0,    1,32'h500,      0,0,0,0,0));

    for (int i = 0; i < vecs.size(); i++)
      applyStimulus(vecs[i], i);

    // Reset while waiting on memory; the late response lands during reset.
    reset_n = 1'b0;
    #1;
    checkOutput("wait_reset_mem_valid", {31'd0, mem_valid}, 32'd0);
    checkOutput("wait_reset_valid_out", {31'd0, valid_out}, 32'd0);
    checkOutput("wait_reset_pc_out", pc_out, 32'd0);
    checkOutput("wait_reset_instruction_out", instruction_out, 32'd0);
    checkOutput("wait_reset_exception_out", {31'd0, exception_out}, 32'd0);
    stall = 1'b0; redirect = 1'b0; mem_ready = 1'b0;
    mem_rvalid = 1'b1; mem_rdata = JUNK; mem_error = 1'b0;
    @(posedge clk);
    #1;
    mem_rvalid = 1'b0;
    reset_n = 1'b1;
    #1;
    checkOutput("post_reset_mem_valid", {31'd0, mem_valid}, 32'd1);
    checkOutput("post_reset_mem_address", mem_address, 32'h0);
    applyStimulus(mk(0,0,0, 1,0,0,0, 1,32'h0, 0,0,0,0,0), 100);
    applyStimulus(mk(0,0,0, 0,1,32'h9999_0000,0, 0,0, 1,32'h0,32'h9999_0000,0,0), 101);

    // Randomized run: memory with random ready/latency, random stall/redirect.
    @(posedge clk);
    #1;
    reset_n = 1'b0; stall = 1'b0; redirect = 1'b0; mem_ready = 1'b0;
    mem_rvalid = 1'b0; mem_error = 1'b0;
    #2;
    reset_n = 1'b1;
    pend = 1'b0; halted = 1'b0; m_valid = 1'b0; m_pc = 32'd0;
    exp_pc = 32'd0; paddr = 32'd0; lat = 0; halt_cnt = 0; deliveries = 0;

    for (int cyc = 0; cyc < 2500; cyc++) begin
      mv = mem_valid;
      ma = mem_address;
      s  = ($urandom_range(0, 99) < 30);
      if (halted) begin
        halt_cnt++;
        r = (halt_cnt >= 3);
      end else begin
        r = ($urandom_range(0, 99) < 4);
      end
      ra  = $urandom & 32'h0000_0FFC;
      rdy = ($urandom_range(0, 99) < 70);
      rv  = pend && (lat == 0);

      checkOutput("rnd_one_outstanding", {31'd0, mv && pend}, 32'd0);
      if (halted)
        checkOutput("rnd_halt_no_request", {31'd0, mv}, 32'd0);
      else if (mv && !r)
        checkOutput("rnd_request_address", ma, exp_pc);

      stall = s; redirect = r; redirect_address = ra; mem_ready = rdy;
      if (rv) begin
        mem_rvalid = 1'b1; mem_rdata = memf(paddr); mem_error = errf(paddr);
      end else begin
        mem_rvalid = 1'b0; mem_rdata = $urandom; mem_error = $urandom_range(0, 1);
      end

      @(posedge clk);
      #1;

      if (rv) pend = 1'b0;
      else if (pend) lat--;
      if (mv && rdy) begin
        pend  = 1'b1;
        paddr = ma;
        lat   = $urandom_range(0, 2);
      end

      if (r) begin
        checkOutput("rnd_redirect_valid", {31'd0, valid_out}, 32'd0);
        checkOutput("rnd_redirect_exception", {31'd0, exception_out}, 32'd0);
        exp_pc = ra; halted = 1'b0; halt_cnt = 0; m_valid = 1'b0;
      end else if (s) begin
        checkOutput("rnd_stall_hold_valid", {31'd0, valid_out}, {31'd0, m_valid});
        if (m_valid)
          checkOutput("rnd_stall_hold_pc", pc_out, m_pc);
      end else if (valid_out) begin
        checkOutput("rnd_deliver_while_halted", {31'd0, halted}, 32'd0);
        e = errf(exp_pc);
        checkOutput("rnd_pc_out", pc_out, exp_pc);
        checkOutput("rnd_next_pc_out", next_pc_out, exp_pc + 32'd4);
        checkOutput("rnd_instruction_out", instruction_out, e ? 32'd0 : memf(exp_pc));
        checkOutput("rnd_exception_out", {31'd0, exception_out}, {31'd0, e});
        if (e)
          checkOutput("rnd_ecause_out", {28'd0, ecause_out}, 32'd1);
        m_valid = 1'b1;
        m_pc    = exp_pc;
        deliveries++;
        if (e) halted = 1'b1;
        else   exp_pc = exp_pc + 32'd4;
      end else begin
        m_valid = 1'b0;
      end
    end
    checkOutput("rnd_progress", {31'd0, deliveries >= 100}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
